// File: rtl/wrr_bcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wrr_bcd_arbiter
// Description : Weighted round-robin arbiter with binary grant, packet lock
//               across multi-flit packets and per-owner burst credits.
// Revision    : 1.0 - initial release
// ============================================================================
module wrr_bcd_arbiter #(
    parameter int ARBITER_WIDTH     = 4,
    parameter int ARBITER_BCD_WIDTH = $clog2(ARBITER_WIDTH),
    parameter int WEIGHT_WIDTH      = 2
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [ARBITER_WIDTH-1:0]              request,
    input  logic [ARBITER_WIDTH*WEIGHT_WIDTH-1:0] weight,
    input  logic                                  grant_accept,
    input  logic                                  tail,
    output logic [ARBITER_BCD_WIDTH-1:0]          grant,
    output logic                                  any_grant,
    output logic                                  locked
);

    localparam int c_sum_w = ARBITER_BCD_WIDTH + 1;

    logic [ARBITER_BCD_WIDTH-1:0] r_last;
    logic [WEIGHT_WIDTH-1:0]      r_credit;
    logic                         r_lock;

    logic [ARBITER_BCD_WIDTH-1:0] w_rr_grant;
    logic                         w_rr_found;
    logic [c_sum_w-1:0]           w_sum;
    logic [ARBITER_BCD_WIDTH-1:0] w_idx;
    logic                         w_continue;
    logic [WEIGHT_WIDTH-1:0]      w_weight;
    logic                         w_acc;

    // Scan last+1 .. last (wrapping); the wider sum keeps indices in range
    // for widths that are not a power of two.
    always_comb begin
        w_rr_grant = '0;
        w_rr_found = 1'b0;
        w_sum      = '0;
        w_idx      = '0;
        for (int k = 1; k <= ARBITER_WIDTH; k++) begin
            w_sum = {1'b0, r_last} + c_sum_w'(k);
            if (w_sum >= c_sum_w'(ARBITER_WIDTH)) begin
                w_sum = w_sum - c_sum_w'(ARBITER_WIDTH);
            end
            w_idx = w_sum[ARBITER_BCD_WIDTH-1:0];
            if (!w_rr_found && request[w_idx]) begin
                w_rr_found = 1'b1;
                w_rr_grant = w_idx;
            end
        end
    end

    assign w_continue = (r_credit != '0) && request[r_last];

    always_comb begin
        grant     = '0;
        any_grant = 1'b0;
        locked    = 1'b0;
        if (!reset) begin
            locked = r_lock;
            if (r_lock) begin
                grant     = r_last;
                any_grant = request[r_last];
            end else if (w_continue) begin
                grant     = r_last;
                any_grant = 1'b1;
            end else begin
                grant     = w_rr_grant;
                any_grant = |request;
            end
        end
    end

    always_comb begin
        w_weight = '0;
        for (int i = 0; i < ARBITER_WIDTH; i++) begin
            if (grant == ARBITER_BCD_WIDTH'(i)) begin
                w_weight = weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            end
        end
    end

    assign w_acc = grant_accept & any_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_last   <= ARBITER_BCD_WIDTH'(ARBITER_WIDTH - 1);
            r_credit <= '0;
            r_lock   <= 1'b0;
        end else if (w_acc) begin
            if (r_lock) begin
                if (tail) begin
                    r_lock <= 1'b0;
                end
            end else begin
                // Packet head: either spend a burst credit or start a new turn.
                if (w_continue) begin
                    r_credit <= r_credit - 1'b1;
                end else begin
                    r_last   <= grant;
                    r_credit <= w_weight;
                end
                r_lock <= ~tail;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wrr_bcd_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wrr_bcd_arbiter
// Description : Directed scoreboard bench for wrr_bcd_arbiter (4- and 5-port).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wrr_bcd_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] request;
    logic [7:0] weight;
    logic       grant_accept;
    logic       tail;
    logic [1:0] grant;
    logic       any_grant;
    logic       locked;

    logic       reset5;
    logic [4:0] request5;
    logic [9:0] weight5;
    logic       grant_accept5;
    logic       tail5;
    logic [2:0] grant5;
    logic       any_grant5;
    logic       locked5;

    typedef struct {
        logic [2:0] g;
        logic       a;
        logic       l;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    wrr_bcd_arbiter #(.ARBITER_WIDTH(4), .WEIGHT_WIDTH(2)) dut (
        .clk(clk), .reset(reset), .request(request), .weight(weight),
        .grant_accept(grant_accept), .tail(tail),
        .grant(grant), .any_grant(any_grant), .locked(locked)
    );

    wrr_bcd_arbiter #(.ARBITER_WIDTH(5), .WEIGHT_WIDTH(2)) dut5 (
        .clk(clk), .reset(reset5), .request(request5), .weight(weight5),
        .grant_accept(grant_accept5), .tail(tail5),
        .grant(grant5), .any_grant(any_grant5), .locked(locked5)
    );

    task automatic compare(input logic [4:0] obs);
        exp_t e;
        logic [4:0] expv;
        e    = sb.pop_front();
        expv = {e.g, e.a, e.l};
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed grant=%0d any=%0b locked=%0b, expected grant=%0d any=%0b locked=%0b",
                   e.tag, obs[4:2], obs[1], obs[0], e.g, e.a, e.l);
        end
    endtask

    // One cycle on the 4-port arbiter: drive, queue expectation, sample mid-cycle.
    task automatic cyc(input string tag, input logic rst, input logic [3:0] req,
                       input logic ga, input logic tl,
                       input logic [1:0] eg, input logic ea, input logic el);
        exp_t e;
        reset = rst; request = req; grant_accept = ga; tail = tl;
        e.g = {1'b0, eg}; e.a = ea; e.l = el; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        compare({1'b0, grant, any_grant, locked});
        @(posedge clk);
        #1;
    endtask

    task automatic cyc5(input string tag, input logic rst, input logic [4:0] req,
                        input logic ga, input logic tl,
                        input logic [2:0] eg, input logic ea, input logic el);
        exp_t e;
        reset5 = rst; request5 = req; grant_accept5 = ga; tail5 = tl;
        e.g = eg; e.a = ea; e.l = el; e.tag = tag;
        sb.push_back(e);
        @(negedge clk);
        compare({grant5, any_grant5, locked5});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; request = '0; weight = '0; grant_accept = 1'b0; tail = 1'b0;
        reset5 = 1'b1; request5 = '0; weight5 = '0; grant_accept5 = 1'b0; tail5 = 1'b0;
        @(posedge clk); #1;

        cyc("reset_hold", 1'b1, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b0, 1'b0);

        // Fair rotation with zero weights
        cyc("rr0", 1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        cyc("rr1", 1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        cyc("rr2", 1'b0, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
        cyc("rr3", 1'b0, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0);
        cyc("rr4", 1'b0, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        cyc("rr5", 1'b0, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);

        // Weighted burst: port 1 gets three packets per turn
        weight = 8'b00_00_10_00;
        cyc("wb0", 1'b0, 4'b0011, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        cyc("wb1", 1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        cyc("wb2", 1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        cyc("wb3", 1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        cyc("wb4", 1'b0, 4'b0011, 1'b1, 1'b1, 2'd0, 1'b1, 1'b0);
        cyc("wb5", 1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        cyc("wb6", 1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        cyc("wb7", 1'b0, 4'b0011, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        weight = '0;

        // Lock hold across a multi-flit packet with the owner stalling
        cyc("lk_rst",   1'b1, 4'b0101, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc("lk_head",  1'b0, 4'b0101, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);
        cyc("lk_stall0", 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        cyc("lk_stall1", 1'b0, 4'b0100, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1);
        cyc("lk_stall2", 1'b0, 4'b0100, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
        cyc("lk_tail",  1'b0, 4'b0101, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1);
        cyc("lk_next",  1'b0, 4'b0101, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0);

        // Credit forfeit: port 1 holds credit 3 but stops requesting
        weight = 8'b00_01_11_00;
        cyc("cf_win1",   1'b0, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);
        cyc("cf_forfeit", 1'b0, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
        cyc("cf_reload", 1'b0, 4'b0110, 1'b1, 1'b1, 2'd2, 1'b1, 1'b0);
        cyc("cf_spent",  1'b0, 4'b0110, 1'b1, 1'b1, 2'd1, 1'b1, 1'b0);

        // Reset mid-packet discards the lock
        cyc("rm_head", 1'b0, 4'b0100, 1'b1, 1'b0, 2'd2, 1'b1, 1'b0);
        cyc("rm_lock", 1'b0, 4'b0100, 1'b0, 1'b0, 2'd2, 1'b1, 1'b1);
        cyc("rm_rst",  1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cyc("rm_after", 1'b0, 4'b1000, 1'b0, 1'b0, 2'd3, 1'b1, 1'b0);

        // Five ports: wrap from last=4 and ignored accepts with no request
        cyc5("w5_rst",     1'b1, 5'b10001, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc5("w5_ignore",  1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        cyc5("w5_wrap0",   1'b0, 5'b10001, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        cyc5("w5_to4",     1'b0, 5'b10001, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0);
        cyc5("w5_back0",   1'b0, 5'b10001, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0);
        cyc5("w5_mid",     1'b0, 5'b01100, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0);
        cyc5("w5_locked",  1'b0, 5'b01000, 1'b0, 1'b0, 3'd2, 1'b0, 1'b1);

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: observed %0d entries left, expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wrr_bcd_arbiter.md
# wrr_bcd_arbiter

Parametrised weighted round-robin arbiter with binary-coded grant, packet-level locking and per-port burst credits. Successor to the two-level masked BCD arbiter used in router VC/switch allocation: same binary grant contract, plus a configurable number of consecutive packets per turn and grant hold across multi-flit (wormhole) packets. Sits between per-port request logic and the crossbar select in each router output stage.

## Interface
- ARBITER_WIDTH, 4, number of requesters (any value ≥2, not necessarily a power of two)
- ARBITER_BCD_WIDTH, log2(ARBITER_WIDTH), width of binary grant
- WEIGHT_WIDTH, 2, width of each per-port weight field
- clk  input  1  clock; all state on rising edge
- reset  input  1  synchronous, active-high reset
- request  input  ARBITER_WIDTH  per-port request, bit i = port i
- weight  input  ARBITER_WIDTH*WEIGHT_WIDTH  port i weight in bits [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]; value w grants w+1 packets per turn
- grant_accept  input  1  downstream consumed the granted flit this cycle
- tail  input  1  accepted flit is last of its packet (qualified by grant_accept)
- grant  output  ARBITER_BCD_WIDTH  binary index of granted port
- any_grant  output  1  grant is valid this cycle
- locked  output  1  mid-packet; grant held on owner

## Operation
- State registers: last (index of current/last owner), credit (WEIGHT_WIDTH bits), lock (1 bit). Reset values: last = ARBITER_WIDTH-1, credit = 0, lock = 0.
- Accept event: acc = grant_accept & any_grant. grant_accept with any_grant=0 is ignored.
- Unlocked selection (lock=0), combinational:
  - Continue: if credit≠0 and request[last] → grant=last.
  - Otherwise round-robin: grant = first i with request[i]=1 scanning last+1, last+2, … wrapping modulo ARBITER_WIDTH, ending at last.
  - any_grant = |request. If request=0 → grant=0, any_grant=0.
- Locked (lock=1): grant=last regardless of other requests; any_grant=request[last]. Owner dropping request does not release lock.
- Updates on acc while unlocked (packet head):
  - Continue case: credit ← credit-1.
  - New winner: last ← grant, credit ← weight[grant] (sampled at this edge).
  - tail=0 → lock ← 1; tail=1 (single-flit packet) → lock stays 0.
- Updates on acc while locked: tail=1 → lock ← 0; credit and last unchanged.
- Credit forfeit: if owner has credit≠0 but request[last]=0 while unlocked, round-robin proceeds; the next winner reloads credit.
- weight=0 on all ports → plain round-robin, one packet per turn.
- Weight changes take effect only at the next new-winner event.

## Timing
- grant/any_grant/locked are combinational from state and request: zero-cycle latency request→grant.
- State changes one edge after acc; new grant visible the following cycle.
- locked = lock register.
- While reset=1: any_grant forced 0, grant=0, locked=0, no state update other than reset values. Reset mid-packet discards the lock; first cycle after reset arbitrates from last=ARBITER_WIDTH-1 (port 0 highest priority).
- Simultaneous tail accept and new requests: release takes effect at edge; re-arbitration next cycle (no same-cycle handover).
- Wrap: last=ARBITER_WIDTH-1 scans from 0; correct for non-power-of-two widths (no out-of-range indices).

## Test plan
- Fair rotation: W=4, weights 0, request=4'b1111, grant_accept=tail=1 every cycle → grant 0,1,2,3,0,1.
- Weighted burst: weight[1]=2, others 0, request=4'b0011, accept+tail each cycle → grant 0,1,1,1,0,1,1,1.
- Lock hold: request=4'b0101, grant 0 accepted with tail=0 → locked=1; drop request[0] for 3 cycles → any_grant=0, grant=0; restore request[0], accept tail=1 → locked=0, next cycle grant=2.
- Credit forfeit: weight[1]=3, port 1 wins single-flit packet, request[1] then drops with request=4'b0100 → grant=2, credit reloads to weight[2].
- Reset mid-packet: locked=1 on port 2, pulse reset one cycle with request=4'b1000 → during reset any_grant=0; next cycle locked=0, grant=3, any_grant=1.
- Odd width/ignored accept: ARBITER_WIDTH=5, last=4, request=5'b10001 → grant=0; grant_accept=1 with request=0 → no state change.
